// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues commands to a pipelined ALU and returns results in order via a credit-limited FWFT buffer; optional macro ALU_OPCHK_EN flags illegal opcodes 4..7
module alu_cmd_sequencer #(
  parameter int DATA_WIDTH  = 512,
  parameter int ALU_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_opcode,
  input  logic [DATA_WIDTH-1:0] cmd_a,
  input  logic [DATA_WIDTH-1:0] cmd_b,
  output logic [2:0]            alu_opcode,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  input  logic [DATA_WIDTH-1:0] alu_result,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [2:0]            rsp_opcode,
  output logic                  rsp_err,
  output logic                  busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  // stage 0 is aligned with the alu_* registers, the last stage with alu_result
  localparam int NS = ALU_LATENCY + 1;
  localparam int IW = $clog2(NS + 1);
  localparam logic [2:0] IDLE = 3'b111;

  typedef struct packed {
    logic       v;
    logic [2:0] op;
    logic       err;
  } tag_t;

  tag_t                  r_tag [NS];
  logic [2:0]            r_alu_opcode;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
  logic [2:0]            r_mem_op [FIFO_DEPTH];
  logic                  r_mem_err [FIFO_DEPTH];
  logic [AW-1:0]         r_wr;
  logic [AW-1:0]         r_rd;
  logic [CW-1:0]         r_count;
  logic [IW-1:0]         w_inflight;
  logic                  w_err;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_pop;

`ifdef ALU_OPCHK_EN
  assign w_err = cmd_opcode[2];
`else
  assign w_err = 1'b0;
`endif

  // Count live tags in the latency pipeline
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < NS; i++) w_inflight = w_inflight + IW'(r_tag[i].v);
  end

  assign cmd_ready  = (32'(w_inflight) + 32'(r_count)) < 32'(FIFO_DEPTH);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_push     = r_tag[NS-1].v;
  assign rsp_valid  = r_count != '0;
  assign w_pop      = rsp_valid && rsp_ready;
  assign rsp_data   = rsp_valid ? r_mem_data[r_rd] : '0;
  assign rsp_opcode = rsp_valid ? r_mem_op[r_rd] : 3'd0;
  assign rsp_err    = rsp_valid && r_mem_err[r_rd];
  assign busy       = (w_inflight != '0) || (r_count != '0);
  assign alu_opcode = r_alu_opcode;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;

  // Drive the ALU on accept and shift tags alongside its pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alu_opcode <= IDLE;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      for (int i = 0; i < NS; i++) r_tag[i] <= '0;
    end else begin
      r_alu_opcode <= (w_accept && !w_err) ? cmd_opcode : IDLE;
      if (w_accept) begin
        r_alu_a <= cmd_a;
        r_alu_b <= cmd_b;
      end
      r_tag[0] <= '{v: w_accept, op: cmd_opcode, err: w_err};
      for (int i = 1; i < NS; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Response buffer pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop) r_rd <= r_rd + AW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  // Capture the result of the tag leaving the pipeline
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr] <= r_tag[NS-1].err ? '0 : alu_result;
      r_mem_op[r_wr]   <= r_tag[NS-1].op;
      r_mem_err[r_wr]  <= r_tag[NS-1].err;
    end
  end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed bench for alu_cmd_sequencer with a small pipelined ALU model
module tb_alu_cmd_sequencer;
  localparam int DW = 512;
  localparam int L  = 3;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_opcode = '0;
  logic [DW-1:0] cmd_a = '0;
  logic [DW-1:0] cmd_b = '0;
  logic [2:0]    alu_opcode;
  logic [DW-1:0] alu_a;
  logic [DW-1:0] alu_b;
  logic [DW-1:0] alu_result;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [2:0]    rsp_opcode;
  logic          rsp_err;
  logic          busy;
  logic [DW-1:0] p0, p1, p2;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DATA_WIDTH(DW), .ALU_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_opcode(rsp_opcode), .rsp_err(rsp_err), .busy(busy)
  );

  function automatic logic [DW-1:0] alu_f(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int s;
    s = int'(b[8:0]);
    case (op)
      3'd0: return {{(DW-1){1'b0}}, ^a};
      3'd1: return DW'($countones(a));
      3'd2: return (a >> s) | (a << (DW - s));
      3'd3: return (a << s) | (a >> (DW - s));
      3'd7: return '0;
      default: return a ^ b;
    endcase
  endfunction

  // ALU model: result valid L cycles after alu_* update
  always_ff @(posedge clk) begin
    p0 <= alu_f(alu_opcode, alu_a, alu_b);
    p1 <= p0;
    p2 <= p1;
  end
  assign alu_result = p2;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit done;
    done = 1'b0;
    cmd_opcode = op;
    cmd_a = a;
    cmd_b = b;
    cmd_valid = 1'b1;
    for (int n = 0; n < 20 && !done; n++) begin
      done = cmd_ready;
      tick;
    end
    cmd_valid = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL issue_timeout op=%0d accepted=0 required=1", op); end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (rsp_valid) begin ok = 1'b1; break; end
      tick;
    end
  endtask

  task automatic test_reset;
    rsp_ready = 1'b0;
    issue(3'd1, 512'hF, '0);
    tick;
    #3 rst = 1'b1;
    #1;
    checks++;
    if ({alu_opcode, rsp_valid, rsp_err, busy, cmd_ready, rsp_opcode} !== {3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL reset_ctrl got op=%0d v=%0b e=%0b busy=%0b rdy=%0b rop=%0d required op=7 v=0 e=0 busy=0 rdy=1 rop=0",
               alu_opcode, rsp_valid, rsp_err, busy, cmd_ready, rsp_opcode);
    end
    checks++;
    if ({alu_a, alu_b, rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data got a=%0h b=%0h d=%0h required 0", alu_a, alu_b, rsp_data);
    end
    @(negedge clk) rst = 1'b0;
    repeat (8) tick;
    checks++;
    if ({rsp_valid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL reset_drop got v=%0b busy=%0b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_single_popcount;
    int n;
    rsp_ready = 1'b1;
    issue(3'd1, 512'hFF, '0);
    checks++;
    if (alu_opcode !== 3'd1 || alu_a !== 512'hFF) begin
      errors++;
      $display("FAIL single_issue got op=%0d a=%0h required op=1 a=ff", alu_opcode, alu_a);
    end
    tick;
    n = 1;
    checks++;
    if (alu_opcode !== 3'b111) begin errors++; $display("FAIL single_idle got op=%0d required 7", alu_opcode); end
    while (!rsp_valid && n < 20) begin tick; n++; end
    checks++;
    if (n != L + 1) begin errors++; $display("FAIL single_latency got %0d required %0d", n, L + 1); end
    checks++;
    if (rsp_data !== 512'd8 || rsp_opcode !== 3'd1 || rsp_err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp got d=%0h op=%0d e=%0b busy=%0b required d=8 op=1 e=0 busy=1", rsp_data, rsp_opcode, rsp_err, busy);
    end
    tick;
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_done got v=%0b busy=%0b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [DW-1:0] one;
    logic [DW-1:0] e [3];
    logic [2:0] eo [3];
    bit ok;
    one = 1;
    e[0] = 1; e[1] = 16; e[2] = one << 511;
    eo[0] = 3'd0; eo[1] = 3'd3; eo[2] = 3'd2;
    rsp_ready = 1'b1;
    issue(3'd0, 1, 0);
    issue(3'd3, 1, 4);
    issue(3'd2, 1, 1);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        checks++;
        if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_gap%0d got v=%0b required 1", k, rsp_valid); end
      end
      wait_rsp(ok);
      checks++;
      if (!ok || rsp_data !== e[k] || rsp_opcode !== eo[k]) begin
        errors++;
        $display("FAIL b2b_rsp%0d got d=%0h op=%0d required d=%0h op=%0d", k, rsp_data, rsp_opcode, e[k], eo[k]);
      end
      tick;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy got %0b required 0", busy); end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] pa [6];
    int idx;
    bit r, v;
    pa[0] = 'h1; pa[1] = 'h3; pa[2] = 'h7; pa[3] = 'hF; pa[4] = 'h1F; pa[5] = 'h3F;
    rsp_ready = 1'b0;
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      v = idx < 6;
      cmd_valid = v;
      cmd_opcode = 3'd1;
      cmd_a = v ? pa[idx] : '0;
      cmd_b = '0;
      r = cmd_ready;
      tick;
      if (r && v) idx++;
    end
    cmd_valid = 1'b0;
    checks++;
    if (idx != D || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept got n=%0d rdy=%0b required n=%0d rdy=0", idx, cmd_ready, D);
    end
    repeat (6) tick;
    checks++;
    if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL bp_full got v=%0b rdy=%0b busy=%0b required 1 0 1", rsp_valid, cmd_ready, busy);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== DW'(k + 1)) begin
        errors++;
        $display("FAIL bp_pop%0d got v=%0b d=%0h required v=1 d=%0h", k, rsp_valid, rsp_data, k + 1);
      end
      tick;
      if (k == 0) begin
        checks++;
        if (cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_credit got rdy=%0b required 1", cmd_ready); end
      end
    end
    checks++;
    if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got v=%0b required 0", rsp_valid); end
  endtask

  task automatic test_push_pop;
    rsp_ready = 1'b0;
    issue(3'd1, 'h1, 0);
    issue(3'd1, 'h3, 0);
    issue(3'd1, 'h7, 0);
    issue(3'd1, 'hF, 0);
    repeat (4) tick;
    checks++;
    if (dut.r_count !== 3'd4 || rsp_data !== 512'd1) begin
      errors++;
      $display("FAIL pp_fill got cnt=%0d d=%0h required cnt=4 d=1", dut.r_count, rsp_data);
    end
    rsp_ready = 1'b1;
    tick;
    rsp_ready = 1'b0;
    checks++;
    if (dut.r_count !== 3'd3 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL pp_pop got cnt=%0d rdy=%0b required cnt=3 rdy=1", dut.r_count, cmd_ready);
    end
    issue(3'd1, 'h1F, 0);
    repeat (3) tick;
    checks++;
    if (dut.r_count !== 3'd3 || rsp_data !== 512'd2) begin
      errors++;
      $display("FAIL pp_pre got cnt=%0d d=%0h required cnt=3 d=2", dut.r_count, rsp_data);
    end
    rsp_ready = 1'b1;
    tick;
    checks++;
    if (dut.r_count !== 3'd3 || rsp_data !== 512'd3 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pp_both got cnt=%0d d=%0h busy=%0b required cnt=3 d=3 busy=1", dut.r_count, rsp_data, busy);
    end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_data !== DW'(k + 3)) begin
        errors++;
        $display("FAIL pp_drain%0d got v=%0b d=%0h required v=1 d=%0h", k, rsp_valid, rsp_data, k + 3);
      end
      tick;
    end
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL pp_end got v=%0b busy=%0b required 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_opchk;
    logic [DW-1:0] ed [3];
    logic [2:0] eo [3];
    logic ee [3];
    logic [2:0] mid_op;
    bit ok;
`ifdef ALU_OPCHK_EN
    ed[1] = 0; ee[1] = 1'b1; mid_op = 3'b111;
`else
    ed[1] = 3; ee[1] = 1'b0; mid_op = 3'd5;
`endif
    ed[0] = 2; ed[2] = 4;
    ee[0] = 1'b0; ee[2] = 1'b0;
    eo[0] = 3'd1; eo[1] = 3'd5; eo[2] = 3'd1;
    rsp_ready = 1'b1;
    issue(3'd1, 'h3, 0);
    issue(3'd5, 'h5, 'h6);
    checks++;
    if (alu_opcode !== mid_op) begin errors++; $display("FAIL opchk_issue got op=%0d required %0d", alu_opcode, mid_op); end
    issue(3'd1, 'hF, 0);
    for (int k = 0; k < 3; k++) begin
      wait_rsp(ok);
      checks++;
      if (!ok || rsp_data !== ed[k] || rsp_opcode !== eo[k] || rsp_err !== ee[k]) begin
        errors++;
        $display("FAIL opchk_rsp%0d got d=%0h op=%0d e=%0b required d=%0h op=%0d e=%0b",
                 k, rsp_data, rsp_opcode, rsp_err, ed[k], eo[k], ee[k]);
      end
      tick;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    test_reset;
    test_single_popcount;
    test_back_to_back;
    test_backpressure;
    test_push_pop;
    test_opchk;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog run did not finish");
    $fatal(1, "watchdog");
  end
endmodule
